bp_cce_hybrid_uc_resp_pipe: RTL and testbench



---
 rtl/bp_cce_hybrid_uc_resp_pipe_pkg.sv | 130 +++++++++++++
 rtl/bp_cce_hybrid_uc_resp_pipe_fifo.sv | 52 +++++
 rtl/bp_cce_hybrid_uc_resp_pipe.sv | 124 ++++++++++++
 tb/tb_bp_cce_hybrid_uc_resp_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cce_hybrid_uc_resp_pipe_pkg.sv
// Types shared by the hybrid CCE uncached response pipe: BedRock mem/LCE headers,
// message enums and the mem-response to LCE-command translation.
package bp_cce_hybrid_uc_resp_pipe_pkg;

   localparam int paddr_width_gp  = 40;
   localparam int lce_id_width_gp = 4;
   localparam int cce_id_width_gp = 4;
   localparam int lce_assoc_gp    = 8;
   localparam int way_id_width_gp = $clog2(lce_assoc_gp);
   localparam int dword_width_gp  = 64;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef enum logic [3:0] {
      e_bedrock_cmd_sync        = 4'd0,
      e_bedrock_cmd_set_clear   = 4'd1,
      e_bedrock_cmd_inv         = 4'd2,
      e_bedrock_cmd_st          = 4'd3,
      e_bedrock_cmd_data        = 4'd4,
      e_bedrock_cmd_st_wakeup   = 4'd5,
      e_bedrock_cmd_wb          = 4'd6,
      e_bedrock_cmd_st_wb       = 4'd7,
      e_bedrock_cmd_tr          = 4'd8,
      e_bedrock_cmd_st_tr       = 4'd9,
      e_bedrock_cmd_st_tr_wb    = 4'd10,
      e_bedrock_cmd_uc_data     = 4'd11,
      e_bedrock_cmd_uc_st_done  = 4'd12
   } bp_bedrock_cmd_type_e;

   typedef enum logic [2:0] {
      e_COH_I = 3'b000,
      e_COH_S = 3'b001,
      e_COH_E = 3'b010,
      e_COH_F = 3'b011,
      e_COH_M = 3'b110,
      e_COH_O = 3'b111
   } bp_coh_states_e;

   typedef enum logic [2:0] {
      e_bedrock_msg_size_1  = 3'd0,
      e_bedrock_msg_size_2  = 3'd1,
      e_bedrock_msg_size_4  = 3'd2,
      e_bedrock_msg_size_8  = 3'd3,
      e_bedrock_msg_size_16 = 3'd4,
      e_bedrock_msg_size_32 = 3'd5,
      e_bedrock_msg_size_64 = 3'd6
   } bp_bedrock_msg_size_e;

   typedef struct packed {
      logic                       uncached;
      bp_coh_states_e             state;
      logic [way_id_width_gp-1:0] way_id;
      logic [lce_id_width_gp-1:0] lce_id;
      logic [cce_id_width_gp-1:0] cce_id;
   } bp_bedrock_mem_payload_s;

   typedef struct packed {
      bp_bedrock_mem_payload_s   payload;
      bp_bedrock_msg_size_e      size;
      logic [paddr_width_gp-1:0] addr;
      bp_bedrock_mem_type_e      msg_type;
   } bp_bedrock_mem_header_s;

   typedef struct packed {
      logic [lce_id_width_gp-1:0] target;
      logic [way_id_width_gp-1:0] target_way_id;
      bp_coh_states_e             state;
      logic [way_id_width_gp-1:0] way_id;
      logic [cce_id_width_gp-1:0] src_id;
      logic [lce_id_width_gp-1:0] dst_id;
   } bp_bedrock_lce_cmd_payload_s;

   typedef struct packed {
      bp_bedrock_lce_cmd_payload_s payload;
      bp_bedrock_msg_size_e        size;
      logic [paddr_width_gp-1:0]   addr;
      bp_bedrock_cmd_type_e        msg_type;
   } bp_bedrock_lce_cmd_header_s;

   localparam int cce_mem_msg_header_width_lp = $bits(bp_bedrock_mem_header_s);
   localparam int lce_cmd_msg_header_width_lp = $bits(bp_bedrock_lce_cmd_header_s);

   typedef struct packed {
      logic                       supported;
      logic                       has_data;
      bp_bedrock_lce_cmd_header_s header;
   } uc_resp_xlate_s;

   // Unsupported response types come back with supported=0 and are dropped by the pipe.
   function automatic uc_resp_xlate_s uc_resp_xlate(input bp_bedrock_mem_header_s m);
      uc_resp_xlate_s x;
      x = '0;
      x.header.addr           = m.addr;
      x.header.size           = m.size;
      x.header.payload.dst_id = m.payload.lce_id;
      x.header.payload.src_id = m.payload.cce_id;
      x.header.payload.way_id = m.payload.way_id;
      case (m.msg_type)
         e_bedrock_mem_uc_rd: begin
            x.supported = 1'b1;
            x.has_data  = 1'b1;
            if (m.payload.uncached) begin
               x.header.msg_type = e_bedrock_cmd_uc_data;
            end else begin
               x.header.msg_type      = e_bedrock_cmd_data;
               x.header.payload.state = m.payload.state;
            end
         end
         e_bedrock_mem_amo: begin
            x.supported       = 1'b1;
            x.has_data        = 1'b1;
            x.header.msg_type = e_bedrock_cmd_uc_data;
         end
         e_bedrock_mem_uc_wr: begin
            x.supported       = 1'b1;
            x.header.msg_type = e_bedrock_cmd_uc_st_done;
         end
         default: ;
      endcase
      return x;
   endfunction

endpackage

// File: rtl/bp_cce_hybrid_uc_resp_pipe_fifo.sv
// Small 1-read/1-write beat buffer with valid/yumi dequeue; ready_o is simply not-full,
// so a full buffer never takes an enqueue in the same cycle as a dequeue.
module bp_cce_hybrid_uc_resp_pipe_fifo #(
   parameter int width_p = 8,
   parameter int els_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic [width_p-1:0]  mem_r [els_p];
   logic [ptr_w_lp-1:0] rptr_r, wptr_r;
   logic [cnt_w_lp-1:0] count_r;
   logic                enq, deq;

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   assign ready_o = (count_r != cnt_w_lp'(els_p));
   assign v_o     = (count_r != '0);
   assign data_o  = mem_r[rptr_r];
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rptr_r  <= '0;
         wptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (enq) wptr_r <= ptr_inc(wptr_r);
         if (deq) rptr_r <= ptr_inc(rptr_r);
         if (enq && !deq)      count_r <= count_r + 1'b1;
         else if (!enq && deq) count_r <= count_r - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wptr_r] <= data_i;
   end

endmodule

// File: rtl/bp_cce_hybrid_uc_resp_pipe.sv
// Hybrid CCE uncached return path: buffers BedRock Stream mem responses and emits one
// BedRock Burst LCE command (uc data, uc store-done, or cacheable fill) per message.
//
// state   | meaning
// e_ready | head beat holds a new message; header offered (or unsupported beat dropped)
// e_data  | header accepted; streaming data beats through last
// e_drain | header-only message accepted; discarding its remaining beats
module bp_cce_hybrid_uc_resp_pipe
   import bp_cce_hybrid_uc_resp_pipe_pkg::*;
#(
   parameter int lce_data_width_p = dword_width_gp,
   parameter int mem_data_width_p = dword_width_gp,
   parameter int beat_fifo_els_p  = 2
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   output logic                                   empty_o,

   input  logic [cce_mem_msg_header_width_lp-1:0] mem_resp_header_i,
   input  logic [mem_data_width_p-1:0]            mem_resp_data_i,
   input  logic                                   mem_resp_v_i,
   output logic                                   mem_resp_ready_and_o,
   input  logic                                   mem_resp_last_i,

   output logic [lce_cmd_msg_header_width_lp-1:0] lce_cmd_header_o,
   output logic                                   lce_cmd_header_v_o,
   input  logic                                   lce_cmd_header_ready_and_i,
   output logic                                   lce_cmd_has_data_o,
   output logic [lce_data_width_p-1:0]            lce_cmd_data_o,
   output logic                                   lce_cmd_data_v_o,
   input  logic                                   lce_cmd_data_ready_and_i,
   output logic                                   lce_cmd_last_o
);

   if (mem_data_width_p != lce_data_width_p) begin : g_width_check
      $fatal(1, "mem_data_width_p must equal lce_data_width_p");
   end

   localparam int fifo_width_lp = 1 + cce_mem_msg_header_width_lp + mem_data_width_p;

   typedef enum logic [1:0] {e_ready, e_data, e_drain} state_e;

   state_e                      state_r, state_n;
   logic                        fifo_ready, head_v, yumi;
   logic [fifo_width_lp-1:0]    head;
   logic                        head_last;
   bp_bedrock_mem_header_s      head_hdr;
   logic [mem_data_width_p-1:0] head_data;
   uc_resp_xlate_s              xl;
   logic                        in_ready_en_r;

   // Holds off input acceptance during reset without using reset_i as a data signal.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) in_ready_en_r <= 1'b0;
      else         in_ready_en_r <= 1'b1;
   end

   assign mem_resp_ready_and_o = fifo_ready & in_ready_en_r;

   bp_cce_hybrid_uc_resp_pipe_fifo #(
      .width_p (fifo_width_lp),
      .els_p   (beat_fifo_els_p)
   ) beat_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (mem_resp_v_i & mem_resp_ready_and_o),
      .data_i  ({mem_resp_last_i, mem_resp_header_i, mem_resp_data_i}),
      .ready_o (fifo_ready),
      .v_o     (head_v),
      .data_o  (head),
      .yumi_i  (yumi)
   );

   assign {head_last, head_hdr, head_data} = head;
   assign xl = uc_resp_xlate(head_hdr);

   assign lce_cmd_header_o   = xl.header;
   assign lce_cmd_has_data_o = xl.has_data;
   assign lce_cmd_data_o     = head_data;
   assign lce_cmd_last_o     = head_last;
   assign empty_o            = ~head_v & (state_r == e_ready);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_r <= e_ready;
      else         state_r <= state_n;
   end

   always_comb begin
      state_n            = state_r;
      lce_cmd_header_v_o = 1'b0;
      lce_cmd_data_v_o   = 1'b0;
      yumi               = 1'b0;
      case (state_r)
         e_ready: begin
            if (head_v && !xl.supported) begin
               yumi = 1'b1;
            end else if (head_v) begin
               lce_cmd_header_v_o = 1'b1;
               if (lce_cmd_header_ready_and_i) begin
                  if (xl.has_data) begin
                     state_n = e_data;
                  end else begin
                     yumi = 1'b1;
                     if (!head_last) state_n = e_drain;
                  end
               end
            end
         end
         e_data: begin
            lce_cmd_data_v_o = head_v;
            if (head_v && lce_cmd_data_ready_and_i) begin
               yumi = 1'b1;
               if (head_last) state_n = e_ready;
            end
         end
         e_drain: begin
            yumi = head_v;
            if (head_v && head_last) state_n = e_ready;
         end
         default: state_n = e_ready;
      endcase
   end

endmodule

// File: tb/tb_bp_cce_hybrid_uc_resp_pipe.sv
// Directed bench for the uncached response pipe: hand-written expected LCE commands,
// checked by a negedge monitor for content, ordering, stability and protocol.
module tb_bp_cce_hybrid_uc_resp_pipe;
   import bp_cce_hybrid_uc_resp_pipe_pkg::*;

   localparam int DW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic empty;
   logic [cce_mem_msg_header_width_lp-1:0] mem_hdr = '0;
   logic [DW-1:0] mem_data = '0;
   logic mem_v = 1'b0, mem_ready, mem_last = 1'b0;
   logic [lce_cmd_msg_header_width_lp-1:0] hdr_o;
   logic hdr_v, hdr_rdy = 1'b0, has_data;
   logic [DW-1:0] data_o;
   logic data_v, data_rdy = 1'b0, last_o;

   bp_cce_hybrid_uc_resp_pipe #(
      .lce_data_width_p(DW), .mem_data_width_p(DW), .beat_fifo_els_p(2)
   ) dut (
      .clk_i(clk), .reset_i(rst), .empty_o(empty),
      .mem_resp_header_i(mem_hdr), .mem_resp_data_i(mem_data), .mem_resp_v_i(mem_v),
      .mem_resp_ready_and_o(mem_ready), .mem_resp_last_i(mem_last),
      .lce_cmd_header_o(hdr_o), .lce_cmd_header_v_o(hdr_v), .lce_cmd_header_ready_and_i(hdr_rdy),
      .lce_cmd_has_data_o(has_data), .lce_cmd_data_o(data_o), .lce_cmd_data_v_o(data_v),
      .lce_cmd_data_ready_and_i(data_rdy), .lce_cmd_last_o(last_o)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   typedef struct {
      logic [3:0] mt; logic [3:0] dst; logic [3:0] src; logic [2:0] way;
      logic [2:0] st; logic [39:0] addr; logic [2:0] sz; logic hd;
   } exp_hdr_t;
   typedef struct { logic [63:0] d; logic last; } exp_beat_t;
   exp_hdr_t  exp_hdr_q[$];
   exp_beat_t exp_data_q[$];

   logic rand_mode = 1'b0, hdr_cfg = 1'b1, data_cfg = 1'b1, abort_tx = 1'b0;

   initial forever begin
      @(posedge clk); #1;
      hdr_rdy  = rand_mode ? 1'($urandom_range(0, 1)) : hdr_cfg;
      data_rdy = rand_mode ? 1'($urandom_range(0, 1)) : data_cfg;
   end

   // Monitor: content, ordering, stall stability and header/data phase rules.
   initial begin
      logic in_msg, hold_h, hold_d;
      logic [lce_cmd_msg_header_width_lp-1:0] held_hdr;
      logic [DW-1:0] held_data;
      logic held_last;
      bp_bedrock_lce_cmd_header_s h;
      exp_hdr_t  e;
      exp_beat_t b;
      in_msg = 0; hold_h = 0; hold_d = 0;
      held_hdr = '0; held_data = '0; held_last = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_msg = 0; hold_h = 0; hold_d = 0;
         end else begin
            if (hold_h) begin
               check_eq("hdr_stall_v", hdr_v, 1);
               check_eq("hdr_stall_stable", 64'(hdr_o == held_hdr), 1);
            end
            if (hold_d) begin
               check_eq("data_stall_v", data_v, 1);
               check_eq("data_stall_stable", data_o, held_data);
               check_eq("last_stall_stable", last_o, held_last);
            end
            hold_h = hdr_v & ~hdr_rdy;  held_hdr  = hdr_o;
            hold_d = data_v & ~data_rdy; held_data = data_o; held_last = last_o;
            if (in_msg) check_eq("hdr_during_data", hdr_v, 0);
            else        check_eq("data_without_hdr", data_v, 0);
            if (hdr_v && hdr_rdy) begin
               if (exp_hdr_q.size() == 0) check_eq("hdr_unexpected", hdr_v, 0);
               else begin
                  e = exp_hdr_q.pop_front();
                  h = bp_bedrock_lce_cmd_header_s'(hdr_o);
                  check_eq("hdr_type",  h.msg_type, e.mt);
                  check_eq("hdr_dst",   h.payload.dst_id, e.dst);
                  check_eq("hdr_src",   h.payload.src_id, e.src);
                  check_eq("hdr_way",   h.payload.way_id, e.way);
                  check_eq("hdr_state", h.payload.state, e.st);
                  check_eq("hdr_other", {h.payload.target, h.payload.target_way_id}, 0);
                  check_eq("hdr_addr",  h.addr, e.addr);
                  check_eq("hdr_size",  h.size, e.sz);
                  check_eq("has_data",  has_data, e.hd);
                  if (has_data) in_msg = 1;
               end
            end
            if (data_v && data_rdy) begin
               if (exp_data_q.size() == 0) check_eq("data_unexpected", data_v, 0);
               else begin
                  b = exp_data_q.pop_front();
                  check_eq("data", data_o, b.d);
                  check_eq("last", last_o, b.last);
                  if (last_o) in_msg = 0;
               end
            end
         end
      end
   end

   function automatic bp_bedrock_mem_header_s mk(input bp_bedrock_mem_type_e t, input logic [39:0] a,
         input bp_bedrock_msg_size_e sz, input logic [3:0] lce, input logic [3:0] cce,
         input logic [2:0] way, input bp_coh_states_e st, input logic unc);
      bp_bedrock_mem_header_s m;
      m = '0;
      m.msg_type = t; m.addr = a; m.size = sz;
      m.payload.lce_id = lce; m.payload.cce_id = cce; m.payload.way_id = way;
      m.payload.state = st; m.payload.uncached = unc;
      return m;
   endfunction

   task automatic expect_msg(input bp_bedrock_cmd_type_e mt, input logic [3:0] dst, input logic [3:0] src,
         input logic [2:0] way, input logic [2:0] st, input logic [39:0] addr, input logic [2:0] sz,
         input logic hd, input logic [63:0] base, input int n);
      exp_hdr_t e;
      exp_beat_t b;
      e.mt = mt; e.dst = dst; e.src = src; e.way = way; e.st = st; e.addr = addr; e.sz = sz; e.hd = hd;
      exp_hdr_q.push_back(e);
      if (hd) for (int i = 0; i < n; i++) begin
         b.d = base + 64'(i); b.last = (i == n - 1);
         exp_data_q.push_back(b);
      end
   endtask

   task automatic sync();
      @(posedge clk); #1;
   endtask

   // Caller is aligned to posedge+1; returns aligned to posedge+1 after the handshake.
   task automatic send_beat(input bp_bedrock_mem_header_s h, input logic [63:0] d, input logic last);
      int t;
      mem_v = 1; mem_hdr = h; mem_data = d; mem_last = last;
      t = 0;
      do begin @(negedge clk); t++; end while (!mem_ready && t < 200 && !abort_tx);
      if (abort_tx) begin mem_v = 0; return; end
      if (!mem_ready) check_eq("send_timeout", mem_ready, 1);
      @(posedge clk); #1;
      mem_v = 0;
   endtask

   task automatic send_msg(input bp_bedrock_mem_header_s h, input logic [63:0] base, input int n);
      for (int i = 0; i < n; i++)
         if (!abort_tx) send_beat(h, base + 64'(i), i == n - 1);
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while ((exp_hdr_q.size() != 0 || exp_data_q.size() != 0 || !empty) && t < 500) begin
         @(negedge clk); #2; t++;
      end
      check_eq({tag, "_idle"}, empty, 1);
      check_eq({tag, "_hdr_left"}, 64'(exp_hdr_q.size()), 0);
      check_eq({tag, "_data_left"}, 64'(exp_data_q.size()), 0);
   endtask

   task automatic wait_done(input string tag, ref logic done);
      int t;
      t = 0;
      while (!done && t < 400) begin @(negedge clk); t++; end
      check_eq(tag, done, 1);
   endtask

   initial begin
      bp_bedrock_mem_header_s m;
      logic tx_done;
      #3;
      check_eq("rst_hdr_v", hdr_v, 0);
      check_eq("rst_data_v", data_v, 0);
      check_eq("rst_ready", mem_ready, 0);
      check_eq("rst_empty", empty, 1);
      repeat (3) @(negedge clk);
      rst = 0;
      sync();

      // uncached read: state is not carried for uc_data
      m = mk(e_bedrock_mem_uc_rd, 40'h80001000, e_bedrock_msg_size_4, 4'd2, 4'd1, 3'd0, e_COH_M, 1'b1);
      expect_msg(e_bedrock_cmd_uc_data, 4'd2, 4'd1, 3'd0, 3'd0, 40'h80001000, 3'd2, 1'b1, 64'hDEADBEEF, 1);
      check_eq("t1_hdr_before", hdr_v, 0);
      send_beat(m, 64'hDEADBEEF, 1'b1);
      check_eq("t1_hdr_latency", hdr_v, 1);
      wait_idle("t1");

      sync();
      m = mk(e_bedrock_mem_uc_wr, 40'h80002008, e_bedrock_msg_size_8, 4'd3, 4'd1, 3'd5, e_COH_I, 1'b1);
      expect_msg(e_bedrock_cmd_uc_st_done, 4'd3, 4'd1, 3'd5, 3'd0, 40'h80002008, 3'd3, 1'b0, 0, 0);
      send_beat(m, 64'h1234, 1'b1);
      wait_idle("t2");

      sync();
      m = mk(e_bedrock_mem_uc_rd, 40'h80003000, e_bedrock_msg_size_64, 4'd1, 4'd2, 3'd6, e_COH_M, 1'b0);
      expect_msg(e_bedrock_cmd_data, 4'd1, 4'd2, 3'd6, 3'b110, 40'h80003000, 3'd6, 1'b1, 64'd0, 8);
      send_msg(m, 64'd0, 8);
      wait_idle("t3");

      sync();
      m = mk(e_bedrock_mem_amo, 40'h800030A0, e_bedrock_msg_size_8, 4'd0, 4'd3, 3'd2, e_COH_S, 1'b0);
      expect_msg(e_bedrock_cmd_uc_data, 4'd0, 4'd3, 3'd2, 3'd0, 40'h800030A0, 3'd3, 1'b1, 64'h55AA, 1);
      send_beat(m, 64'h55AA, 1'b1);
      wait_idle("t4");

      // unsupported type: both beats dropped with no LCE output
      sync();
      m = mk(e_bedrock_mem_rd, 40'h80003100, e_bedrock_msg_size_16, 4'd4, 4'd0, 3'd1, e_COH_E, 1'b0);
      send_msg(m, 64'h77, 2);
      wait_idle("t5");

      // random backpressure, back-to-back messages
      rand_mode = 1;
      sync();
      expect_msg(e_bedrock_cmd_uc_data, 4'd4, 4'd0, 3'd1, 3'd0, 40'h80004000, 3'd3, 1'b1, 64'hA0, 1);
      expect_msg(e_bedrock_cmd_data, 4'd5, 4'd1, 3'd7, 3'b010, 40'h80005000, 3'd5, 1'b1, 64'hB0, 4);
      expect_msg(e_bedrock_cmd_uc_st_done, 4'd6, 4'd2, 3'd0, 3'd0, 40'h80006000, 3'd0, 1'b0, 0, 0);
      expect_msg(e_bedrock_cmd_uc_data, 4'd7, 4'd3, 3'd3, 3'd0, 40'h80007000, 3'd3, 1'b1, 64'hC0, 1);
      send_msg(mk(e_bedrock_mem_uc_rd, 40'h80004000, e_bedrock_msg_size_8, 4'd4, 4'd0, 3'd1, e_COH_I, 1'b1), 64'hA0, 1);
      send_msg(mk(e_bedrock_mem_uc_rd, 40'h80005000, e_bedrock_msg_size_32, 4'd5, 4'd1, 3'd7, e_COH_E, 1'b0), 64'hB0, 4);
      send_msg(mk(e_bedrock_mem_uc_wr, 40'h80006000, e_bedrock_msg_size_1, 4'd6, 4'd2, 3'd0, e_COH_I, 1'b1), 64'hEE, 1);
      send_msg(mk(e_bedrock_mem_amo, 40'h80007000, e_bedrock_msg_size_8, 4'd7, 4'd3, 3'd3, e_COH_I, 1'b0), 64'hC0, 1);
      wait_idle("t6");
      rand_mode = 0;

      // full buffer: data side stalled
      hdr_cfg = 1; data_cfg = 0;
      sync(); sync();
      m = mk(e_bedrock_mem_uc_rd, 40'h80008000, e_bedrock_msg_size_64, 4'd1, 4'd0, 3'd2, e_COH_S, 1'b0);
      expect_msg(e_bedrock_cmd_data, 4'd1, 4'd0, 3'd2, 3'b001, 40'h80008000, 3'd6, 1'b1, 64'h100, 8);
      tx_done = 0;
      fork begin send_msg(m, 64'h100, 8); tx_done = 1; end join_none
      repeat (12) @(negedge clk);
      #1;
      check_eq("t7_full_ready", mem_ready, 0);
      check_eq("t7_data_v", data_v, 1);
      check_eq("t7_head_data", data_o, 64'h100);
      check_eq("t7_head_last", last_o, 0);
      data_cfg = 1;
      wait_done("t7_tx_done", tx_done);
      wait_idle("t7");

      // reset in the middle of an 8-beat message
      data_cfg = 0;
      sync(); sync();
      m = mk(e_bedrock_mem_uc_rd, 40'h80009000, e_bedrock_msg_size_64, 4'd2, 4'd1, 3'd4, e_COH_M, 1'b0);
      expect_msg(e_bedrock_cmd_data, 4'd2, 4'd1, 3'd4, 3'b110, 40'h80009000, 3'd6, 1'b1, 64'h200, 8);
      tx_done = 0;
      fork begin send_msg(m, 64'h200, 8); tx_done = 1; end join_none
      repeat (6) @(negedge clk);
      #2;
      check_eq("t8_hdr_sent", 64'(exp_hdr_q.size()), 0);
      check_eq("t8_data_v_before", data_v, 1);
      rst = 1; abort_tx = 1;
      #1;
      check_eq("t8_hdr_v", hdr_v, 0);
      check_eq("t8_data_v", data_v, 0);
      check_eq("t8_ready", mem_ready, 0);
      check_eq("t8_empty", empty, 1);
      exp_data_q.delete();
      wait_done("t8_tx_abort", tx_done);
      mem_v = 0;
      data_cfg = 1;
      repeat (2) @(negedge clk);
      rst = 0; abort_tx = 0;
      sync();
      m = mk(e_bedrock_mem_uc_wr, 40'h8000A010, e_bedrock_msg_size_8, 4'd5, 4'd2, 3'd3, e_COH_I, 1'b1);
      expect_msg(e_bedrock_cmd_uc_st_done, 4'd5, 4'd2, 3'd3, 3'd0, 40'h8000A010, 3'd3, 1'b0, 0, 0);
      send_beat(m, 64'h0, 1'b1);
      wait_idle("t8");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
